// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver blocks.
//   timer_state_t     : state encoding of the rx_timer bit-timing FSM
//   UART_CLKS_PER_BIT : default clocks per serial bit
//   UART_DATA_BITS    : default data bits per frame
//   clog2_max(a, b)   : width needed to hold any value 0 .. max(a, b)
package uart_rx_pkg;

  localparam int UART_CLKS_PER_BIT = 10;
  localparam int UART_DATA_BITS    = 8;

  typedef enum logic [1:0] {
    DISABLED   = 2'd0,
    FIRST_WAIT = 2'd1,
    SAMPLING   = 2'd2,
    DONE       = 2'd3
  } timer_state_t;

  function automatic int clog2_max(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/rx_timer_flex_counter.sv
// Parameterized up-counter with synchronous clear and terminal-value detect.
//   clk, n_rst    : clock and synchronous active-low reset
//   clear         : synchronous clear, wins over count_enable
//   count_enable  : advance the count by one this edge
//   rollover_val  : terminal value; reaching it clears (or holds, if SATURATE)
//   count_out     : registered count
//   rollover_flag : high when this edge's increment reaches rollover_val
module flex_counter #(
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             count_enable,
  input  logic [WIDTH-1:0] rollover_val,
  output logic [WIDTH-1:0] count_out,
  output logic             rollover_flag
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_inc;
  logic             at_terminal;
  logic             hit;

  assign count_inc   = count_q + WIDTH'(1);
  assign at_terminal = SATURATE && (count_q == rollover_val);
  // The flag looks ahead at the incremented value so the owner can act on
  // the very edge the counter reaches its terminal value.
  assign hit           = count_enable && !at_terminal && (count_inc == rollover_val);
  assign rollover_flag = !clear && hit;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable && !at_terminal) begin
      if (count_inc == rollover_val) begin
        count_d = SATURATE ? rollover_val : '0;
      end else begin
        count_d = count_inc;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values; reset is synchronous, checked inside the clocked block.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_out = count_q;

endmodule

// File: rtl/rx_timer.sv
// Bit-timing stage of the UART receiver. While enable_timer is high it emits
// one shift_strobe at the centre of each data bit and of the stop bit, then
// holds packet_done until enable_timer falls.
//   clk, n_rst   : clock and synchronous active-low reset
//   enable_timer : level; low aborts timing and clears the block
//   shift_strobe : registered one-cycle pulse per sampled bit
//   packet_done  : registered level, high from the cycle after the last strobe
//   bit_count    : registered number of strobes issued in this frame
module rx_timer
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS,
  // 1.5 bit periods to the centre of data bit 0, minus the two cycles the
  // control FSM spends getting here.
  parameter int FIRST_DELAY  = (3 * CLKS_PER_BIT) / 2 - 2
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           enable_timer,
  output logic                           shift_strobe,
  output logic                           packet_done,
  output logic [$clog2(DATA_BITS+2)-1:0] bit_count
);

  localparam int NUM_BITS = DATA_BITS + 1;
  localparam int BIT_W    = $clog2(NUM_BITS + 1);
  localparam int CNT_W    = clog2_max(FIRST_DELAY, CLKS_PER_BIT);

  timer_state_t     state_q, state_d;
  logic             shift_strobe_q, shift_strobe_d;
  logic             packet_done_q, packet_done_d;

  logic             clk_count_en;
  logic [CNT_W-1:0] clk_rollover;
  logic             clk_hit;
  logic             bit_hit;
  logic [CNT_W-1:0] unused_clk_count;

  // Counting runs in every enabled state except DONE; DISABLED counts too so
  // the enabling edge is already edge n = 1.
  assign clk_count_en = enable_timer && (state_q != DONE);
  assign clk_rollover = (state_q == SAMPLING) ? CNT_W'(CLKS_PER_BIT)
                                              : CNT_W'(FIRST_DELAY);

  flex_counter #(
    .WIDTH    (CNT_W),
    .SATURATE (1'b0)
  ) u_clk_counter (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (!enable_timer),
    .count_enable  (clk_count_en),
    .rollover_val  (clk_rollover),
    .count_out     (unused_clk_count),
    .rollover_flag (clk_hit)
  );

  flex_counter #(
    .WIDTH    (BIT_W),
    .SATURATE (1'b1)
  ) u_bit_counter (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (!enable_timer),
    .count_enable  (clk_hit),
    .rollover_val  (BIT_W'(NUM_BITS)),
    .count_out     (bit_count),
    .rollover_flag (bit_hit)
  );

  always_comb begin
    state_d        = state_q;
    shift_strobe_d = 1'b0;
    packet_done_d  = 1'b0;
    if (!enable_timer) begin
      state_d = DISABLED;
    end else begin
      shift_strobe_d = clk_hit;
      packet_done_d  = (state_q == DONE);
      unique case (state_q)
        DISABLED, FIRST_WAIT: state_d = clk_hit ? SAMPLING : FIRST_WAIT;
        SAMPLING:             if (bit_hit) state_d = DONE;
        DONE:                 state_d = DONE;
        default:              state_d = DISABLED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q        <= DISABLED;
      shift_strobe_q <= 1'b0;
      packet_done_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      shift_strobe_q <= shift_strobe_d;
      packet_done_q  <= packet_done_d;
    end
  end

  assign shift_strobe = shift_strobe_q;
  assign packet_done  = packet_done_q;

endmodule

// File: tb/tb_rx_timer.sv
// Self-checking bench for rx_timer: one default instance (10/8/13) and one
// small instance (4/5/4) share clock, reset and enable. Each cycle a model
// derived from the enabled-edge count pushes expected outputs to a queue,
// which is popped and compared 1 time unit after the edge. A vector table of
// segments adds spot checks on the default instance at segment ends.
module tb_rx_timer;

  logic       clk;
  logic       n_rst;
  logic       enable_timer;
  logic       shift_strobe_a, packet_done_a;
  logic [3:0] bit_count_a;
  logic       shift_strobe_b, packet_done_b;
  logic [2:0] bit_count_b;

  rx_timer u_dut_a (
    .clk          (clk),
    .n_rst        (n_rst),
    .enable_timer (enable_timer),
    .shift_strobe (shift_strobe_a),
    .packet_done  (packet_done_a),
    .bit_count    (bit_count_a)
  );

  rx_timer #(
    .CLKS_PER_BIT (4),
    .DATA_BITS    (5),
    .FIRST_DELAY  (4)
  ) u_dut_b (
    .clk          (clk),
    .n_rst        (n_rst),
    .enable_timer (enable_timer),
    .shift_strobe (shift_strobe_b),
    .packet_done  (packet_done_b),
    .bit_count    (bit_count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit s_a; bit d_a; int bc_a;
    bit s_b; bit d_b; int bc_b;
  } exp_t;

  typedef struct {
    string name;
    bit    rst_n;
    bit    en;
    int    cycles;
    bit    exp_strobe;
    bit    exp_done;
    int    exp_bc;
  } vec_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   na    = 0;
  int   nb    = 0;

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d", name, cyc, actual, expected);
    end
  endtask

  // Expected outputs after enabled edge n, from the closed-form timing.
  function automatic void model(input int n, input int c, input int fd, input int nbits,
                                output bit s, output bit d, output int bc);
    int k;
    s  = 1'b0;
    d  = 1'b0;
    bc = 0;
    if (n >= fd) begin
      k  = (n - fd) / c;
      s  = ((n - fd) % c == 0) && (k < nbits);
      bc = (k + 1 < nbits) ? k + 1 : nbits;
      d  = (n >= fd + (nbits - 1) * c + 1);
    end
  endfunction

  task automatic tick(input bit rst_v, input bit en_v);
    exp_t e;
    exp_t g;
    n_rst        = rst_v;
    enable_timer = en_v;
    na = (rst_v && en_v) ? na + 1 : 0;
    nb = (rst_v && en_v) ? nb + 1 : 0;
    model(na, 10, 13, 9, e.s_a, e.d_a, e.bc_a);
    model(nb, 4, 4, 6, e.s_b, e.d_b, e.bc_b);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    g = sb_q.pop_front();
    check("a_strobe",    int'(shift_strobe_a), int'(g.s_a));
    check("a_done",      int'(packet_done_a),  int'(g.d_a));
    check("a_bit_count", int'(bit_count_a),    g.bc_a);
    check("b_strobe",    int'(shift_strobe_b), int'(g.s_b));
    check("b_done",      int'(packet_done_b),  int'(g.d_b));
    check("b_bit_count", int'(bit_count_b),    g.bc_b);
  endtask

  vec_t vecs[$];

  initial begin
    n_rst        = 1'b0;
    enable_timer = 1'b0;

    // Segments on the default instance; expectations are for the last edge.
    vecs.push_back('{"reset_hold",      1'b0, 1'b1,  3, 1'b0, 1'b0, 0});
    vecs.push_back('{"first_wait",      1'b1, 1'b1, 12, 1'b0, 1'b0, 0});
    vecs.push_back('{"first_strobe",    1'b1, 1'b1,  1, 1'b1, 1'b0, 1});
    vecs.push_back('{"strobe_width",    1'b1, 1'b1,  1, 1'b0, 1'b0, 1});
    vecs.push_back('{"second_strobe",   1'b1, 1'b1,  9, 1'b1, 1'b0, 2});
    vecs.push_back('{"last_strobe",     1'b1, 1'b1, 70, 1'b1, 1'b0, 9});
    vecs.push_back('{"done_rise",       1'b1, 1'b1,  1, 1'b0, 1'b1, 9});
    vecs.push_back('{"done_hold",       1'b1, 1'b1,  6, 1'b0, 1'b1, 9});
    vecs.push_back('{"disable_clear",   1'b1, 1'b0,  1, 1'b0, 1'b0, 0});
    vecs.push_back('{"run_to_40",       1'b1, 1'b1, 40, 1'b0, 1'b0, 3});
    vecs.push_back('{"abort",           1'b1, 1'b0,  3, 1'b0, 1'b0, 0});
    vecs.push_back('{"restart_strobe",  1'b1, 1'b1, 13, 1'b1, 1'b0, 1});
    vecs.push_back('{"run_to_22",       1'b1, 1'b1,  9, 1'b0, 1'b0, 1});
    vecs.push_back('{"disable_at_23",   1'b1, 1'b0,  1, 1'b0, 1'b0, 0});
    vecs.push_back('{"run_to_50",       1'b1, 1'b1, 50, 1'b0, 1'b0, 4});
    vecs.push_back('{"reset_mid_frame", 1'b0, 1'b1,  1, 1'b0, 1'b0, 0});
    vecs.push_back('{"after_reset",     1'b1, 1'b1, 13, 1'b1, 1'b0, 1});

    foreach (vecs[i]) begin
      for (int c = 0; c < vecs[i].cycles; c++) tick(vecs[i].rst_n, vecs[i].en);
      check({vecs[i].name, "_strobe"}, int'(shift_strobe_a), int'(vecs[i].exp_strobe));
      check({vecs[i].name, "_done"},   int'(packet_done_a),  int'(vecs[i].exp_done));
      check({vecs[i].name, "_bc"},     int'(bit_count_a),    vecs[i].exp_bc);
    end

    // Small instance: full frame from a clean start, done after edge 25.
    tick(1'b1, 1'b0);
    for (int c = 0; c < 24; c++) tick(1'b1, 1'b1);
    check("b_last_strobe", int'(shift_strobe_b), 1);
    check("b_before_done", int'(packet_done_b),  0);
    tick(1'b1, 1'b1);
    check("b_done_25",     int'(packet_done_b),  1);
    check("b_bc_full",     int'(bit_count_b),    6);

    // One-cycle enable blips: each must leave no residue.
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    for (int c = 0; c < 4; c++) tick(1'b1, 1'b1);
    check("blip_b_first", int'(shift_strobe_b), 1);
    for (int c = 0; c < 9; c++) tick(1'b1, 1'b1);
    check("blip_a_first", int'(shift_strobe_a), 1);
    check("blip_a_bc",    int'(bit_count_a),    1);
    tick(1'b1, 1'b0);

    check("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_timer.md
# rx_timer

Bit-timing stage of the UART receiver, sitting between the receiver control FSM and the shift register. While the control FSM holds `enable_timer` high, it produces one `shift_strobe` pulse at the centre of each data bit and of the stop bit. After the last strobe it raises `packet_done`, which the control FSM waits on before checking the stop bit.

## Interface
- `CLKS_PER_BIT`, default 10: clocks per serial bit; must be ≥ 2.
- `DATA_BITS`, default 8: data bits per frame. Strobes per frame `NUM_BITS` = `DATA_BITS` + 1 (the extra strobe is the stop bit).
- `FIRST_DELAY`, default 13: enabled cycles to the first strobe.
  - Equals 1.5 × `CLKS_PER_BIT` − 2, which accounts for the two cycles the control FSM spends reaching its timing state.
  - Must be ≥ 1.
- `clk`, input, 1: sole clock, rising edge.
- `n_rst`, input, 1: **synchronous, active-low reset**, sampled on the rising edge of `clk`.
- `enable_timer`, input, 1: level. High means a frame is being timed; low aborts timing and clears the block.
- `shift_strobe`, output, 1: registered, one-cycle pulse per sampled bit.
- `packet_done`, output, 1: registered level. High from the cycle after the final strobe until `enable_timer` falls.
- `bit_count`, output, `$clog2(NUM_BITS+1)`: registered count of strobes issued in the current frame.

## Operation
- FSM states:
  - `DISABLED`: all counters 0, outputs 0.
  - `FIRST_WAIT`: counting toward the first strobe.
  - `SAMPLING`: counting full bit periods.
  - `DONE`: counters frozen, `packet_done` = 1.
- Transitions, evaluated at each rising edge:
  - Any state: `n_rst` = 0 → `DISABLED`, with every register and output cleared. This takes priority over everything else.
  - Any state: `enable_timer` = 0 → `DISABLED`.
  - `DISABLED` with `enable_timer` = 1 → `FIRST_WAIT`. The clock counter becomes 1; that edge is enabled edge n = 1.
  - `FIRST_WAIT`: when the clock counter reaches `FIRST_DELAY` → `SAMPLING`. On that edge, set strobe, set `bit_count` = 1 and clear the clock counter to 0.
  - `SAMPLING`: the clock counter increments each edge. When it reaches `CLKS_PER_BIT`, strobe, increment `bit_count` and clear the clock counter.
  - `SAMPLING`: when a strobe brings `bit_count` to `NUM_BITS` → `DONE`. `packet_done` rises on the next edge.
  - `DONE`: stays until `enable_timer` = 0.
- `shift_strobe` is high only in the cycle following the edge that produced it. It is never high in two consecutive cycles.
- Width and arithmetic:
  - Clock counter is unsigned, width `$clog2(max(FIRST_DELAY, CLKS_PER_BIT) + 1)`.
  - No counter ever wraps past its terminal value. Terminal compare is equality; the counter is cleared on match.
  - `bit_count` saturates at `NUM_BITS`.

## Timing
- Reset values: `shift_strobe` = 0, `packet_done` = 0, `bit_count` = 0, state `DISABLED`.
- Numbering enabled edges n = 1, 2, … from the first edge with `enable_timer` = 1:
  - Strobes are high after edges n = `FIRST_DELAY` + k·`CLKS_PER_BIT`, for k = 0 … `NUM_BITS` − 1. With defaults: after edges 13, 23, …, 93.
  - `packet_done` goes high after edge `FIRST_DELAY` + (`NUM_BITS` − 1)·`CLKS_PER_BIT` + 1. With defaults: after edge 94.
- `enable_timer` falling: the first edge sampling it low clears all outputs. Any strobe that would have fired on that edge is suppressed.
- Reset mid-frame: identical to the `enable_timer`-low case. Reset wins even if `enable_timer` = 1 on that edge.
- Re-enable one cycle after disable: timing restarts from n = 1 with no residue from the previous frame.
- Latency from `enable_timer` rising to the first strobe is exactly `FIRST_DELAY` edges. There is no combinational path from any input to any output.

## Structure
- Shared package `uart_rx_pkg`, containing:
  - State enum `timer_state_t`.
  - Default localparams `UART_CLKS_PER_BIT` = 10 and `UART_DATA_BITS` = 8.
  - Function `clog2_max(a, b)` for the counter widths.
- Natural sub-module: `flex_counter`, a parameterized-width counter with synchronous clear, count enable, rollover value and a rollover flag.
  - Instanced twice: once as the clock counter (rollover set by state to `FIRST_DELAY` or `CLKS_PER_BIT`) and once as the bit counter (rollover `NUM_BITS`).
  - Reset is synchronous, active-low, same port names as `rx_timer`.
- The top of `rx_timer` holds the FSM and the output registers only.

## Test plan
- Reset: hold `n_rst` = 0 for 3 edges with `enable_timer` = 1 → all outputs 0 and no strobe. Release reset → first strobe after the 13th enabled edge.
- Full frame, defaults: `enable_timer` = 1 held for 100 cycles → 9 strobes, after edges 13, 23, …, 93, each one cycle wide. `bit_count` steps 1 … 9. `packet_done` goes high after edge 94 and stays high.
- Abort: drop `enable_timer` after edge 40 → outputs 0 from the next edge, no further strobes, `bit_count` = 0. Re-enable → strobes after edges 13, 23, … of the new count.
- Disable exactly at a strobe edge: `enable_timer` = 0 sampled on edge 23 → no strobe in that cycle and `bit_count` = 0.
- Reset mid-frame: `n_rst` = 0 on edge 50 while enabled → all outputs 0 after that edge. After release with enable still high, restart from n = 1.
- Parameters `CLKS_PER_BIT` = 4, `DATA_BITS` = 5, `FIRST_DELAY` = 4 → strobes after edges 4, 8, …, 24 (6 strobes). `packet_done` high after edge 25.
